// File: rtl/peripheral_uart_autobaud.sv
// ---------------------------------------------------------------------------
// peripheral_uart_autobaud
//
// Measures an incoming 0x55 sync character (8N1, LSB first) on the raw RX
// line. From it, the block derives the UART bit period and hands the divisor
// to the receiver. While no lock is held, the software divisor and enable
// pass straight through. The receiver stays disabled for the whole
// measurement, so it never sees the sync character.
//
// Ports
//   clk_i         clock
//   rstn_i        asynchronous active-low reset
//   rx_i          raw UART line (shared with the receiver)
//   ab_start_i    single-cycle pulse: start a measurement
//   ab_abort_i    return to IDLE from any state (highest priority)
//   cfg_div_sw_i  software divisor
//   cfg_en_sw_i   software receiver enable
//   cfg_div_o     divisor to the receiver
//   cfg_rx_en_o   enable to the receiver
//   busy_o        measurement in progress (WAIT_START, MEASURE, CHECK)
//   locked_o      a measured divisor is being driven
//   err_o         sticky error flag
//   err_code_o    01 timeout, 10 overflow/range, 11 pattern mismatch
//   err_clr_i     clears err_o / err_code_o (wins over a simultaneous set)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module peripheral_uart_autobaud #(
    parameter int CNT_W      = 20,
    parameter int TIMEOUT    = 20'hFFFFF,
    parameter int MIN_PERIOD = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rx_i,
    input  logic        ab_start_i,
    input  logic        ab_abort_i,
    input  logic [15:0] cfg_div_sw_i,
    input  logic        cfg_en_sw_i,
    output logic [15:0] cfg_div_o,
    output logic        cfg_rx_en_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    input  logic        err_clr_i
);
    localparam int PW = CNT_W - 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_MEASURE,
        S_CHECK,
        S_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] w_q, w_d;
    logic [CNT_W-1:0] t_q, t_d;
    logic [1:0]       falls_q, falls_d;
    logic             w_done_q, w_done_d;
    logic [15:0]      div_q, div_d;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic             err_set;
    logic [1:0]       err_set_code;

    logic             fall_det, rise_det, cnt_max;
    logic [PW-1:0]    p, p_m1, win_lo, win_hi;
    logic             range_bad, pattern_bad;

    // Edges are taken between the two oldest synchronizer stages.
    assign fall_det = sync_q[2] & ~sync_q[1];
    assign rise_det = ~sync_q[2] & sync_q[1];
    assign cnt_max  = &cnt_q;

    // T spans 8 bit periods (start edge to the falling edge of bit 7).
    assign p      = t_q[CNT_W-1:3];
    assign p_m1   = p - PW'(1);
    assign win_lo = p - (p >> 2);
    assign win_hi = p + (p >> 2);

    // A zero period wraps p_m1, but the MIN_PERIOD test catches it first.
    assign range_bad   = (p < PW'(MIN_PERIOD)) || (64'(p_m1) > 64'h0000_0000_0000_FFFF);
    assign pattern_bad = (w_q < CNT_W'(win_lo)) || (w_q > CNT_W'(win_hi));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_d          = w_q;
        t_d          = t_q;
        falls_d      = falls_q;
        w_done_d     = w_done_q;
        div_d        = div_q;
        err_set      = 1'b0;
        err_set_code = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (ab_start_i) begin
                    state_d = S_WAIT_START;
                    cnt_d   = '0;
                end
            end
            S_WAIT_START: begin
                cnt_d = cnt_q + 1'b1;
                if (fall_det) begin
                    state_d  = S_MEASURE;
                    cnt_d    = '0;
                    falls_d  = 2'd0;
                    w_done_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d      = S_IDLE;
                    err_set      = 1'b1;
                    err_set_code = 2'b01;
                end
            end
            S_MEASURE: begin
                if (cnt_max) begin
                    // Character longer than the counter can span.
                    state_d      = S_IDLE;
                    err_set      = 1'b1;
                    err_set_code = 2'b10;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Only the start bit's width is kept as the cross-check.
                    if (rise_det && !w_done_q) begin
                        w_d      = cnt_q + 1'b1;
                        w_done_d = 1'b1;
                    end
                    if (fall_det) begin
                        falls_d = falls_q + 2'd1;
                        if (falls_q == 2'd3) begin
                            t_d     = cnt_q + 1'b1;
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (range_bad) begin
                    state_d      = S_IDLE;
                    err_set      = 1'b1;
                    err_set_code = 2'b10;
                end else if (pattern_bad) begin
                    state_d      = S_IDLE;
                    err_set      = 1'b1;
                    err_set_code = 2'b11;
                end else begin
                    div_d   = 16'(p_m1);
                    state_d = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (ab_start_i) begin
                    state_d = S_WAIT_START;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every transition, including error exits.
        if (ab_abort_i) begin
            state_d = S_IDLE;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= S_IDLE;
            sync_q     <= 3'b111;
            cnt_q      <= '0;
            w_q        <= '0;
            t_q        <= '0;
            falls_q    <= 2'd0;
            w_done_q   <= 1'b0;
            div_q      <= 16'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[1:0], rx_i};
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            t_q      <= t_d;
            falls_q  <= falls_d;
            w_done_q <= w_done_d;
            div_q    <= div_d;
            if (err_clr_i) begin
                err_q      <= 1'b0;
                err_code_q <= 2'b00;
            end else if (err_set) begin
                err_q      <= 1'b1;
                err_code_q <= err_set_code;
            end
        end
    end

    assign busy_o      = (state_q == S_WAIT_START) || (state_q == S_MEASURE) || (state_q == S_CHECK);
    assign locked_o    = (state_q == S_LOCKED);
    assign cfg_div_o   = locked_o ? div_q : cfg_div_sw_i;
    assign cfg_rx_en_o = ((state_q == S_IDLE) || locked_o) ? cfg_en_sw_i : 1'b0;
    assign err_o       = err_q;
    assign err_code_o  = err_code_q;

endmodule
